// File: rtl/math_cordic_pkg.sv
// Shared constants for the CORDIC complex-magnitude pipeline.
// The phase path (MATH_CABS_PHASE_EN) uses the atan table and quadrant type.
package math_cordic_pkg;

    localparam int unsigned KINV_W = 17;
    localparam logic [KINV_W-1:0] KINV_Q17 = 17'd79594;

    // atan(2^-i) scaled so that 2^31 represents pi
    localparam logic [31:0] ATAN_Q31 [0:23] = '{
        32'h2000_0000, 32'h12E4_051D, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2E, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2F9, 32'h0000_517C,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A2F, 32'h0000_0517,
        32'h0000_028B, 32'h0000_0145, 32'h0000_00A2, 32'h0000_0051
    };

    typedef enum logic {
        QuadRight = 1'b0,
        QuadLeft  = 1'b1
    } quad_e;

    function automatic int unsigned cordic_lat(input int unsigned iter);
        return iter + 32'd2;
    endfunction

endpackage

// File: rtl/math_cordic_stage.sv
// One registered CORDIC vectoring micro-rotation with valid/sideband (and z) pass-through.
// z port and atan constant exist only with MATH_CABS_PHASE_EN.
module math_cordic_stage
    import math_cordic_pkg::*;
#(
    parameter int unsigned IW    = 20,
    parameter int unsigned SHIFT = 0,
    parameter int unsigned SB_W  = 4
`ifdef MATH_CABS_PHASE_EN
    ,
    parameter int unsigned ZW    = 18,
    parameter logic [ZW-1:0] ATAN = '0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic signed [IW-1:0] x_i,
    input  logic signed [IW-1:0] y_i,
    input  logic [SB_W-1:0]      sb_i,
`ifdef MATH_CABS_PHASE_EN
    input  logic signed [ZW-1:0] z_i,
    output logic signed [ZW-1:0] z_o,
`endif
    output logic                 valid_o,
    output logic signed [IW-1:0] x_o,
    output logic signed [IW-1:0] y_o,
    output logic [SB_W-1:0]      sb_o
);

    logic                 rot_neg;
    logic signed [IW-1:0] x_sh, y_sh;
    logic signed [IW-1:0] x_d, y_d;
    logic signed [IW-1:0] x_q, y_q;
    logic                 valid_q;
    logic [SB_W-1:0]      sb_q;
`ifdef MATH_CABS_PHASE_EN
    logic signed [ZW-1:0] z_d, z_q;
`endif

    always_comb begin
        rot_neg = y_i[IW-1];
        x_sh    = x_i >>> SHIFT;
        y_sh    = y_i >>> SHIFT;
        if (rot_neg) begin
            x_d = x_i - y_sh;
            y_d = y_i + x_sh;
        end else begin
            x_d = x_i + y_sh;
            y_d = y_i - x_sh;
        end
`ifdef MATH_CABS_PHASE_EN
        z_d = rot_neg ? (z_i - $signed(ATAN)) : (z_i + $signed(ATAN));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
        end
    end

    // Datapath needs no reset: outputs are qualified by valid at the gain stage.
    always_ff @(posedge clk) begin
        x_q  <= x_d;
        y_q  <= y_d;
        sb_q <= sb_i;
`ifdef MATH_CABS_PHASE_EN
        z_q  <= z_d;
`endif
    end

    assign valid_o = valid_q;
    assign x_o     = x_q;
    assign y_o     = y_q;
    assign sb_o    = sb_q;
`ifdef MATH_CABS_PHASE_EN
    assign z_o     = z_q;
`endif

endmodule

// File: rtl/math_cabs_cordic.sv
// Pipelined |a + jb| via CORDIC vectoring: prerotate, ITER micro-rotations, gain; LAT = ITER+2.
// Define MATH_CABS_PHASE_EN to add the z path and the dout_phase output.
module math_cabs_cordic
    import math_cordic_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ITER   = 16,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned GUARD  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din_valid,
    input  logic signed [DATA_W-1:0] dina,
    input  logic signed [DATA_W-1:0] dinb,
    input  logic [TAG_W-1:0]         din_tag,
    output logic                     dout_valid,
    output logic [DATA_W:0]          dout,
    output logic [TAG_W-1:0]         dout_tag
`ifdef MATH_CABS_PHASE_EN
    ,
    output logic signed [DATA_W-1:0] dout_phase
`endif
);

    localparam int unsigned IW = DATA_W + 2 + GUARD;
`ifdef MATH_CABS_PHASE_EN
    localparam int unsigned ZW   = DATA_W + GUARD;
    localparam int unsigned SB_W = TAG_W + 1;   // tag plus quadrant bit
    localparam logic [ZW-1:0] PI_Z = ZW'(1) << (ZW - 1);
`else
    localparam int unsigned SB_W = TAG_W;
`endif

    logic                 v_p  [ITER+1];
    logic signed [IW-1:0] x_p  [ITER+1];
    logic signed [IW-1:0] y_p  [ITER+1];
    logic [SB_W-1:0]      sb_p [ITER+1];
`ifdef MATH_CABS_PHASE_EN
    logic signed [ZW-1:0] z_p  [ITER+1];
`endif

    // Stage 0: fold the left half-plane onto the right (rotate by pi).
    logic                 v0_q;
    logic signed [IW-1:0] a_ext, b_ext;
    logic signed [IW-1:0] x0_d, y0_d, x0_q, y0_q;
    logic [SB_W-1:0]      sb0_d, sb0_q;

    always_comb begin
        a_ext = IW'(dina) <<< GUARD;
        b_ext = IW'(dinb) <<< GUARD;
        x0_d  = dina[DATA_W-1] ? -a_ext : a_ext;
        y0_d  = dina[DATA_W-1] ? -b_ext : b_ext;
`ifdef MATH_CABS_PHASE_EN
        sb0_d = {dina[DATA_W-1], din_tag};
`else
        sb0_d = din_tag;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q <= 1'b0;
        end else begin
            v0_q <= din_valid;
        end
    end

    always_ff @(posedge clk) begin
        x0_q  <= x0_d;
        y0_q  <= y0_d;
        sb0_q <= sb0_d;
    end

    assign v_p[0]  = v0_q;
    assign x_p[0]  = x0_q;
    assign y_p[0]  = y0_q;
    assign sb_p[0] = sb0_q;
`ifdef MATH_CABS_PHASE_EN
    assign z_p[0]  = '0;
`endif

    for (genvar g = 0; g < ITER; g++) begin : g_stage
`ifdef MATH_CABS_PHASE_EN
        localparam logic [63:0] ATAN_EXT = {ATAN_Q31[g], 32'h0} >> (64 - ZW);
        math_cordic_stage #(
            .IW   (IW),
            .SHIFT(g),
            .SB_W (SB_W),
            .ZW   (ZW),
            .ATAN (ATAN_EXT[ZW-1:0])
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .valid_i(v_p[g]),
            .x_i    (x_p[g]),
            .y_i    (y_p[g]),
            .sb_i   (sb_p[g]),
            .z_i    (z_p[g]),
            .z_o    (z_p[g+1]),
            .valid_o(v_p[g+1]),
            .x_o    (x_p[g+1]),
            .y_o    (y_p[g+1]),
            .sb_o   (sb_p[g+1])
        );
`else
        math_cordic_stage #(
            .IW   (IW),
            .SHIFT(g),
            .SB_W (SB_W)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .valid_i(v_p[g]),
            .x_i    (x_p[g]),
            .y_i    (y_p[g]),
            .sb_i   (sb_p[g]),
            .valid_o(v_p[g+1]),
            .x_o    (x_p[g+1]),
            .y_o    (y_p[g+1]),
            .sb_o   (sb_p[g+1])
        );
`endif
    end

    // Gain stage: x is non-negative here, so an unsigned multiply is safe.
    logic [IW+KINV_W-1:0] prod;
    logic [DATA_W:0]      mag_d;

    always_comb begin
        prod  = (IW + KINV_W)'($unsigned(x_p[ITER])) * (IW + KINV_W)'(KINV_Q17);
        mag_d = (DATA_W + 1)'(prod >> (KINV_W + GUARD));
    end

    logic              dout_valid_q;
    logic [DATA_W:0]   dout_q;
    logic [TAG_W-1:0]  dout_tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            dout_tag_q   <= '0;
        end else begin
            dout_valid_q <= v_p[ITER];
            dout_q       <= v_p[ITER] ? mag_d : '0;
            dout_tag_q   <= v_p[ITER] ? sb_p[ITER][TAG_W-1:0] : '0;
        end
    end

    assign dout_valid = dout_valid_q;
    assign dout       = dout_q;
    assign dout_tag   = dout_tag_q;

`ifdef MATH_CABS_PHASE_EN
    logic signed [ZW-1:0]     z_fin;
    logic signed [DATA_W-1:0] phase_d;
    logic signed [DATA_W-1:0] phase_q;

    // Undo the stage-0 half-plane fold; +pi and -pi coincide after wrap.
    always_comb begin
        z_fin = z_p[ITER];
        if (quad_e'(sb_p[ITER][TAG_W]) == QuadLeft) begin
            z_fin = z_p[ITER] + $signed(PI_Z);
        end
        phase_d = DATA_W'(z_fin >>> GUARD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= v_p[ITER] ? phase_d : '0;
        end
    end

    assign dout_phase = phase_q;
`endif

endmodule
